// File: rtl/osd_mam_wb_burst_if.sv
// Bridge from MAM request/write/read streams to a Wishbone B3 master with optional incrementing bursts.
// Latency: read strobe 1 cycle after request accept; minimum 2 cycles per beat in either direction.
// Backpressure: req_ready only in IDLE; write_ready only in WDATA; read_valid holds in RHOLD until read_ready.
module osd_mam_wb_burst_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int BURST_MODE     = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_rw,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_burst,
  input  logic [13:0]             req_beats,
  input  logic                    write_valid,
  output logic                    write_ready,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [DATA_WIDTH/8-1:0] write_strb,
  output logic                    read_valid,
  input  logic                    read_ready,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    cyc_o,
  output logic                    stb_o,
  output logic                    we_o,
  input  logic                    ack_i,
  input  logic                    err_i,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic [DATA_WIDTH-1:0]   dat_o,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  output logic [DATA_WIDTH/8-1:0] sel_o,
  output logic [2:0]              cti_o,
  output logic [1:0]              bte_o,
  output logic                    busy_o,
  output logic [15:0]             err_count_o
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, WDATA, WBUS, RBUS, RHOLD} state_t;

  state_t          state;
  logic [13:0]     beats_left;   // beats still to terminate, including the current one
  logic            multi;        // request has more than one beat
  logic [TW-1:0]   tmo_cnt;      // strobe cycles already elapsed on the current beat
  logic [13:0]     req_cnt;
  logic            tmo_hit;
  logic            term;
  logic            term_err;
  logic            last_beat;

  // Burst tag for a beat: incrementing burst until the final beat, classic otherwise.
  function automatic logic [2:0] cti_for(input logic is_multi, input logic is_last);
    if (BURST_MODE != 0 && is_multi)
      return is_last ? 3'b111 : 3'b010;
    return 3'b000;
  endfunction

  // Beat termination decode: err wins over a simultaneous ack; timeout behaves as err.
  always_comb begin
    req_cnt   = (req_burst && req_beats != 14'd0) ? req_beats : 14'd1;
    tmo_hit   = (TIMEOUT_CYCLES != 0) && stb_o && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    term      = stb_o && (ack_i || err_i || tmo_hit);
    term_err  = stb_o && (err_i || tmo_hit);
    last_beat = (beats_left == 14'd1);
  end

  assign bte_o = 2'b00;

  // Single FSM with all bus and stream outputs registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      beats_left  <= '0;
      multi       <= 1'b0;
      tmo_cnt     <= '0;
      req_ready   <= 1'b0;
      write_ready <= 1'b0;
      read_valid  <= 1'b0;
      read_data   <= '0;
      cyc_o       <= 1'b0;
      stb_o       <= 1'b0;
      we_o        <= 1'b0;
      addr_o      <= '0;
      dat_o       <= '0;
      sel_o       <= '0;
      cti_o       <= 3'b000;
      busy_o      <= 1'b0;
      err_count_o <= '0;
    end else begin
      // stb always drops between beats, so idling the counter while stb is low restarts it per beat
      if (!stb_o) tmo_cnt <= '0;
      else        tmo_cnt <= tmo_cnt + 1'b1;

      if (term_err && err_count_o != 16'hFFFF)
        err_count_o <= err_count_o + 16'd1;

      case (state)
        IDLE: begin
          if (!req_ready) begin
            req_ready <= 1'b1;
          end else if (req_valid) begin
            req_ready  <= 1'b0;
            busy_o     <= 1'b1;
            addr_o     <= req_addr;
            we_o       <= req_rw;
            beats_left <= req_cnt;
            multi      <= (req_cnt > 14'd1);
            if (req_rw) begin
              write_ready <= 1'b1;
              state       <= WDATA;
            end else begin
              cyc_o <= 1'b1;
              stb_o <= 1'b1;
              sel_o <= '1;
              cti_o <= cti_for(req_cnt > 14'd1, req_cnt == 14'd1);
              state <= RBUS;
            end
          end
        end
        WDATA: begin
          if (write_valid) begin
            write_ready <= 1'b0;
            dat_o       <= write_data;
            sel_o       <= write_strb;
            cyc_o       <= 1'b1;
            stb_o       <= 1'b1;
            cti_o       <= cti_for(multi, last_beat);
            state       <= WBUS;
          end
        end
        WBUS: begin
          if (term) begin
            stb_o      <= 1'b0;
            beats_left <= beats_left - 14'd1;
            if (!last_beat) begin
              addr_o      <= addr_o + ADDR_WIDTH'(SW);
              write_ready <= 1'b1;
              state       <= WDATA;
            end else begin
              cyc_o  <= 1'b0;
              we_o   <= 1'b0;
              cti_o  <= 3'b000;
              busy_o <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        RBUS: begin
          if (term) begin
            stb_o      <= 1'b0;
            read_valid <= 1'b1;
            read_data  <= term_err ? '0 : dat_i;
            beats_left <= beats_left - 14'd1;
            state      <= RHOLD;
          end
        end
        RHOLD: begin
          if (read_ready) begin
            read_valid <= 1'b0;
            if (beats_left != 14'd0) begin
              addr_o <= addr_o + ADDR_WIDTH'(SW);
              stb_o  <= 1'b1;
              cti_o  <= cti_for(multi, beats_left == 14'd1);
              state  <= RBUS;
            end else begin
              cyc_o  <= 1'b0;
              cti_o  <= 3'b000;
              busy_o <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_osd_mam_wb_burst_if.sv
// Bench for osd_mam_wb_burst_if: cycle table for single write and 4-beat read burst, then directed sequences.
// Two instances: 32-bit with a 16-cycle timeout, and 64-bit for wrap and lane-width checks.
// Slave is either table-driven or an automatic zero-wait responder returning addr ^ KEY.
module tb_osd_mam_wb_burst_if;

  localparam logic [31:0] KEY = 32'h5A5A_0000;
  localparam logic [31:0] DB  = 32'hDEAD_BEEF;
  localparam logic [31:0] NO_ERR = 32'hFFFF_FFF0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A signals (32-bit)
  logic        req_valid = 0, req_rw = 0, req_burst = 0, write_valid = 0, read_ready = 0;
  logic [31:0] req_addr = 0, write_data = 0;
  logic [13:0] req_beats = 0;
  logic [3:0]  write_strb = 0;
  logic        req_ready, write_ready, read_valid, cyc_o, stb_o, we_o, ack, err, busy_o;
  logic [31:0] read_data, addr_o, dat_o, dat_i;
  logic [3:0]  sel_o;
  logic [2:0]  cti_o;
  logic [1:0]  bte_o;
  logic [15:0] err_count_o;

  // slave control
  logic        auto_slv = 0, silent = 0, tv_ack = 0, tv_err = 0;
  logic [31:0] tv_di = 0, err_addr = NO_ERR;

  assign ack   = auto_slv ? (stb_o && !silent) : tv_ack;
  assign err   = auto_slv ? (stb_o && addr_o == err_addr) : tv_err;
  assign dat_i = auto_slv ? (addr_o ^ KEY) : tv_di;

  osd_mam_wb_burst_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BURST_MODE(1), .TIMEOUT_CYCLES(16)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_addr(req_addr),
    .req_burst(req_burst), .req_beats(req_beats),
    .write_valid(write_valid), .write_ready(write_ready), .write_data(write_data), .write_strb(write_strb),
    .read_valid(read_valid), .read_ready(read_ready), .read_data(read_data),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .ack_i(ack), .err_i(err),
    .addr_o(addr_o), .dat_o(dat_o), .dat_i(dat_i), .sel_o(sel_o), .cti_o(cti_o), .bte_o(bte_o),
    .busy_o(busy_o), .err_count_o(err_count_o)
  );

  // DUT B signals (64-bit), zero-wait auto-ack slave
  logic        req_valid_b = 0, req_burst_b = 0, write_valid_b = 0;
  logic [31:0] req_addr_b = 0;
  logic [13:0] req_beats_b = 0;
  logic [63:0] write_data_b = 0;
  logic [7:0]  write_strb_b = 0;
  logic        req_ready_b, write_ready_b, read_valid_b, cyc_b, stb_b, we_b, busy_b;
  logic [63:0] read_data_b, dat_o_b;
  logic [31:0] addr_b;
  logic [7:0]  sel_b;
  logic [2:0]  cti_b;
  logic [1:0]  bte_b;
  logic [15:0] errc_b;

  osd_mam_wb_burst_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .BURST_MODE(1), .TIMEOUT_CYCLES(1024)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_rw(1'b1), .req_addr(req_addr_b),
    .req_burst(req_burst_b), .req_beats(req_beats_b),
    .write_valid(write_valid_b), .write_ready(write_ready_b), .write_data(write_data_b), .write_strb(write_strb_b),
    .read_valid(read_valid_b), .read_ready(1'b1), .read_data(read_data_b),
    .cyc_o(cyc_b), .stb_o(stb_b), .we_o(we_b), .ack_i(stb_b), .err_i(1'b0),
    .addr_o(addr_b), .dat_o(dat_o_b), .dat_i(64'h0), .sel_o(sel_b), .cti_o(cti_b), .bte_o(bte_b),
    .busy_o(busy_b), .err_count_o(errc_b)
  );

  typedef struct {
    logic        rv, rw;
    logic [31:0] addr;
    logic        burst;
    logic [13:0] beats;
    logic        wv;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic        rr, ack, err;
    logic [31:0] di;
    logic [6:0]  flags;  // {cyc, stb, we, req_ready, write_ready, read_valid, busy}
    logic [31:0] e_addr, e_dato;
    logic [3:0]  e_sel;
    logic [2:0]  e_cti;
    logic [31:0] e_rdata;
    logic [15:0] e_errc;
  } vec_t;

  vec_t tv[16];
  int vectors = 0;
  int miscompares = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Bounded wait on a DUT A condition: 0 req_ready, 1 read_valid, 3 cyc low
  task automatic wait_a(input int which, input string nm);
    logic hit;
    for (int i = 0; i < 64; i++) begin
      case (which)
        0:       hit = req_ready;
        1:       hit = read_valid;
        default: hit = !cyc_o;
      endcase
      if (hit) return;
      step();
    end
    vectors++;
    miscompares++;
    $display("FAIL %s: wait expired after 64 cycles", nm);
  endtask

  // One write request on DUT B; records strobed addresses and cti of the first two beats
  task automatic run_b(input logic [31:0] a, input logic [13:0] beats,
                       output int n, output logic [31:0] a0, output logic [31:0] a1,
                       output logic [2:0] c0, output logic [2:0] c1, output logic [7:0] s0);
    n = 0; a0 = 'x; a1 = 'x; c0 = 'x; c1 = 'x; s0 = 'x;
    for (int i = 0; i < 64 && !req_ready_b; i++) step();
    req_valid_b = 1; req_addr_b = a; req_burst_b = 1; req_beats_b = beats;
    write_valid_b = 1; write_data_b = 64'h0123_4567_89AB_CDEF; write_strb_b = 8'hC3;
    step();
    req_valid_b = 0;
    for (int i = 0; i < 64; i++) begin
      if (stb_b) begin
        if (n == 0) begin a0 = addr_b; c0 = cti_b; s0 = sel_b; end
        if (n == 1) begin a1 = addr_b; c1 = cti_b; end
        n++;
      end
      if (n > 0 && !busy_b) break;
      step();
    end
    write_valid_b = 0;
  endtask

  initial begin
    int terms, errs, n;
    logic [31:0] last_addr, a0, a1;
    logic [2:0]  c0, c1;
    logic [7:0]  s0;
    logic        found;

    //          rv    rw    addr          burst beats    wv    wd        ws     rr    ack   err   di
    //          flags        e_addr        e_dato    e_sel  e_cti   e_rdata       e_errc
    tv[0]  = '{1'b0,1'b0,32'h0,   1'b0,14'd0,1'b0,32'h0,4'h0,1'b0,1'b0,1'b0,32'h0,
               7'b0000000,32'h0,   32'h0,4'h0,3'b000,32'h0,       16'd0};
    tv[1]  = '{1'b1,1'b1,32'h100, 1'b0,14'd0,1'b0,32'h0,4'h0,1'b0,1'b0,1'b0,32'h0,
               7'b0001000,32'h0,   32'h0,4'h0,3'b000,32'h0,       16'd0};
    tv[2]  = '{1'b0,1'b0,32'h0,   1'b0,14'd0,1'b1,DB,   4'h3,1'b0,1'b0,1'b0,32'h0,
               7'b0010101,32'h100, 32'h0,4'h0,3'b000,32'h0,       16'd0};
    tv[3]  = '{1'b0,1'b0,32'h0,   1'b0,14'd0,1'b0,32'h0,4'h0,1'b0,1'b1,1'b0,32'h0,
               7'b1110001,32'h100, DB,   4'h3,3'b000,32'h0,       16'd0};
    tv[4]  = '{1'b0,1'b0,32'h0,   1'b0,14'd0,1'b0,32'h0,4'h0,1'b0,1'b0,1'b0,32'h0,
               7'b0000000,32'h100, DB,   4'h3,3'b000,32'h0,       16'd0};
    tv[5]  = '{1'b1,1'b0,32'h200, 1'b1,14'd4,1'b0,32'h0,4'h0,1'b1,1'b0,1'b0,32'h0,
               7'b0001000,32'h100, DB,   4'h3,3'b000,32'h0,       16'd0};
    tv[6]  = '{1'b0,1'b0,32'h0,   1'b0,14'd0,1'b0,32'h0,4'h0,1'b1,1'b1,1'b0,32'hA000_0000,
               7'b1100001,32'h200, DB,   4'hF,3'b010,32'h0,       16'd0};
    tv[7]  = '{1'b0,1'b0,32'h0,   1'b0,14'd0,1'b0,32'h0,4'h0,1'b1,1'b0,1'b0,32'h0,
               7'b1000011,32'h200, DB,   4'hF,3'b010,32'hA000_0000,16'd0};
    tv[8]  = '{1'b0,1'b0,32'h0,   1'b0,14'd0,1'b0,32'h0,4'h0,1'b1,1'b1,1'b0,32'hA000_0001,
               7'b1100001,32'h204, DB,   4'hF,3'b010,32'hA000_0000,16'd0};
    tv[9]  = '{1'b0,1'b0,32'h0,   1'b0,14'd0,1'b0,32'h0,4'h0,1'b1,1'b0,1'b0,32'h0,
               7'b1000011,32'h204, DB,   4'hF,3'b010,32'hA000_0001,16'd0};
    tv[10] = '{1'b0,1'b0,32'h0,   1'b0,14'd0,1'b0,32'h0,4'h0,1'b1,1'b1,1'b0,32'hA000_0002,
               7'b1100001,32'h208, DB,   4'hF,3'b010,32'hA000_0001,16'd0};
    tv[11] = '{1'b0,1'b0,32'h0,   1'b0,14'd0,1'b0,32'h0,4'h0,1'b1,1'b0,1'b0,32'h0,
               7'b1000011,32'h208, DB,   4'hF,3'b010,32'hA000_0002,16'd0};
    tv[12] = '{1'b0,1'b0,32'h0,   1'b0,14'd0,1'b0,32'h0,4'h0,1'b1,1'b1,1'b0,32'hA000_0003,
               7'b1100001,32'h20C, DB,   4'hF,3'b111,32'hA000_0002,16'd0};
    tv[13] = '{1'b0,1'b0,32'h0,   1'b0,14'd0,1'b0,32'h0,4'h0,1'b1,1'b0,1'b0,32'h0,
               7'b1000011,32'h20C, DB,   4'hF,3'b111,32'hA000_0003,16'd0};
    tv[14] = '{1'b0,1'b0,32'h0,   1'b0,14'd0,1'b0,32'h0,4'h0,1'b0,1'b0,1'b0,32'h0,
               7'b0000000,32'h20C, DB,   4'hF,3'b000,32'hA000_0003,16'd0};
    tv[15] = '{1'b0,1'b0,32'h0,   1'b0,14'd0,1'b0,32'h0,4'h0,1'b0,1'b0,1'b0,32'h0,
               7'b0001000,32'h20C, DB,   4'hF,3'b000,32'hA000_0003,16'd0};

    // reset state while rst is held
    #12;
    chk("reset_state_a", {cyc_o, stb_o, we_o, addr_o, dat_o, sel_o, cti_o, bte_o, req_ready,
                          write_ready, read_valid, read_data, busy_o, err_count_o}, 128'h0);
    chk("reset_state_b", {cyc_b, stb_b, addr_b, sel_b, cti_b, req_ready_b, busy_b, errc_b}, 128'h0);
    @(posedge clk); #1;
    rst = 0;

    // cycle table: single write, then 4-beat zero-wait read burst
    for (int i = 0; i < 16; i++) begin
      req_valid = tv[i].rv; req_rw = tv[i].rw; req_addr = tv[i].addr; req_burst = tv[i].burst;
      req_beats = tv[i].beats; write_valid = tv[i].wv; write_data = tv[i].wd; write_strb = tv[i].ws;
      read_ready = tv[i].rr; tv_ack = tv[i].ack; tv_err = tv[i].err; tv_di = tv[i].di;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {cyc_o, stb_o, we_o, req_ready, write_ready, read_valid, busy_o, addr_o, dat_o, sel_o,
           cti_o, bte_o, read_data, err_count_o},
          {tv[i].flags, tv[i].e_addr, tv[i].e_dato, tv[i].e_sel, tv[i].e_cti, 2'b00,
           tv[i].e_rdata, tv[i].e_errc});
      @(posedge clk); #1;
    end

    auto_slv = 1;

    // back-pressure: 3-beat read, read_ready low 5 cycles on beat 2
    wait_a(0, "bp_req_ready");
    req_valid = 1; req_rw = 0; req_addr = 32'h300; req_burst = 1; req_beats = 3; read_ready = 0;
    step();
    req_valid = 0;
    wait_a(1, "bp_beat1");
    chk("bp_beat1_data", read_data, 32'h300 ^ KEY);
    read_ready = 1; step(); read_ready = 0;
    wait_a(1, "bp_beat2");
    chk("bp_beat2_data", read_data, 32'h304 ^ KEY);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("bp_hold%0d", k), {read_valid, stb_o, cyc_o, read_data}, {1'b1, 1'b0, 1'b1, 32'h304 ^ KEY});
    end
    read_ready = 1; step(); read_ready = 0;
    chk("bp_next_stb", {stb_o, addr_o, cti_o}, {1'b1, 32'h308, 3'b111});
    wait_a(1, "bp_beat3");
    chk("bp_beat3_data", read_data, 32'h308 ^ KEY);
    read_ready = 1; step(); read_ready = 0;
    wait_a(3, "bp_cyc_drop");

    // 3-beat write with err (ack and err together) on beat 2
    wait_a(0, "err_req_ready");
    err_addr = 32'h404;
    req_valid = 1; req_rw = 1; req_addr = 32'h400; req_burst = 1; req_beats = 3;
    write_valid = 1; write_data = 32'h1122_3344; write_strb = 4'hF;
    step();
    req_valid = 0;
    terms = 0; errs = 0; last_addr = 0;
    for (int i = 0; i < 40; i++) begin
      if (stb_o && (ack || err)) begin terms++; last_addr = addr_o; end
      if (stb_o && err) errs++;
      if (!cyc_o && !busy_o && terms > 0) break;
      step();
    end
    write_valid = 0; err_addr = NO_ERR;
    chk("err_beats_issued", terms, 3);
    chk("err_last_addr", last_addr, 32'h408);
    chk("err_count_1", err_count_o, 16'd1);

    // timeout on a silent slave
    wait_a(0, "tmo_req_ready");
    silent = 1;
    req_valid = 1; req_rw = 0; req_addr = 32'h500; req_burst = 0; req_beats = 0; read_ready = 0;
    step();
    req_valid = 0;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (read_valid) break;
      if (stb_o) n++;
      step();
    end
    chk("tmo_stb_cycles", n, 16);
    chk("tmo_read_data", {read_valid, read_data}, {1'b1, 32'h0});
    chk("tmo_err_count", err_count_o, 16'd2);
    silent = 0;
    read_ready = 1; step(); read_ready = 0;
    wait_a(3, "tmo_cyc_drop");

    // reset during beat 3 of an 8-beat read
    wait_a(0, "rst_req_ready");
    req_valid = 1; req_rw = 0; req_addr = 32'h600; req_burst = 1; req_beats = 8; read_ready = 1;
    step();
    req_valid = 0;
    found = 0;
    for (int i = 0; i < 64; i++) begin
      if (stb_o && addr_o == 32'h608) begin found = 1; break; end
      step();
    end
    chk("rst_reached_beat3", found, 1'b1);
    #2 rst = 1;
    #1;
    chk("rst_async_zero", {cyc_o, stb_o, we_o, addr_o, dat_o, sel_o, cti_o, bte_o, req_ready,
                           write_ready, read_valid, read_data, busy_o, err_count_o}, 128'h0);
    step(); step();
    rst = 0;
    wait_a(0, "post_rst_req_ready");
    req_valid = 1; req_rw = 0; req_addr = 32'h700; req_burst = 0; req_beats = 0; read_ready = 1;
    step();
    req_valid = 0;
    wait_a(1, "post_rst_read");
    chk("post_rst_data", {read_data, err_count_o}, {32'h700 ^ KEY, 16'd0});
    step();
    wait_a(3, "post_rst_cyc_drop");

    // 64-bit: 2-beat write wrapping past the top of the address space
    run_b(32'hFFFF_FFF8, 14'd2, n, a0, a1, c0, c1, s0);
    chk("wrap_beats", n, 2);
    chk("wrap_beat1", {a0, c0, s0}, {32'hFFFF_FFF8, 3'b010, 8'hC3});
    chk("wrap_beat2", {a1, c1}, {32'h0000_0000, 3'b111});
    // burst with zero beat count is a single classic beat
    run_b(32'h40, 14'd0, n, a0, a1, c0, c1, s0);
    chk("zero_beats_count", n, 1);
    chk("zero_beats_tag", {a0, c0}, {32'h40, 3'b000});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/osd_mam_wb_burst_if.md
# osd_mam_wb_burst_if

Burst-capable, width-generic bridge from the OSD Memory Access Module (MAM) request/write/read streams to a Wishbone B3 master port. It sits between `osd_mam` and the system bus, replacing the fixed single-beat adapter. It adds:
- 8/16/32/64-bit data paths;
- optional incrementing-burst cycle tags;
- bus-error handling and a transfer timeout, so a MAM packet always completes.

## Interface
- `DATA_WIDTH`, 32: data bits; one of 8, 16, 32, 64. SW = DATA_WIDTH/8 byte lanes.
- `ADDR_WIDTH`, 32: byte-address bits.
- `BURST_MODE`, 1: 1 = tag multi-beat transfers as incrementing bursts; 0 = classic cycles only.
- `TIMEOUT_CYCLES`, 1024: stb-to-ack limit in cycles; 0 disables the timeout.
- `clk_i`  in  1  sole clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `req_valid` / `req_ready`  in / out  1  request handshake.
- `req_rw`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH  start byte address.
- `req_burst`  in  1  1 = multi-beat request.
- `req_beats`  in  14  beat count when `req_burst`=1.
- `write_valid` / `write_ready`  in / out  1  write-data handshake.
- `write_data`  in  DATA_WIDTH  write beat data.
- `write_strb`  in  SW  write beat byte strobes.
- `read_valid` / `read_ready`  out / in  1  read-data handshake.
- `read_data`  out  DATA_WIDTH  read beat data.
- `cyc_o`, `stb_o`, `we_o`  out  1  Wishbone cycle, strobe and write enable.
- `ack_i`, `err_i`  in  1  Wishbone cycle termination.
- `addr_o`  out  ADDR_WIDTH  byte address.
- `dat_o`  out  DATA_WIDTH  write data.
- `dat_i`  in  DATA_WIDTH  read data.
- `sel_o`  out  SW  byte select.
- `cti_o`  out  3  cycle type identifier.
- `bte_o`  out  2  burst type extension.
- `busy_o`  out  1  high in any state other than IDLE.
- `err_count_o`  out  16  count of errored or timed-out beats; saturates at 16'hFFFF.

## Operation
- All outputs are registered.
- On reset every output is 0: `cyc_o`, `stb_o`, `we_o`, `addr_o`, `dat_o`, `sel_o`, `cti_o`, `bte_o`, `req_ready`, `write_ready`, `read_valid`, `read_data`, `busy_o`, `err_count_o`.
- States: IDLE, WDATA, WBUS, RBUS, RHOLD.
- **IDLE:** `req_ready`=1. On `req_valid`&`req_ready`:
  - latch the address into `addr_o`;
  - latch the beat count: `req_burst`=0 → 1; `req_burst`=1 with `req_beats`=0 → 1; otherwise `req_beats`;
  - latch the direction into `we_o`;
  - next state: WDATA if write, RBUS if read.
  - `cyc_o` rises on entry to WBUS/RBUS.
- **WDATA:**
  - `write_ready`=1, `stb_o`=0, `cyc_o` held once set.
  - On `write_valid`: register `dat_o`←`write_data` and `sel_o`←`write_strb`, then go to WBUS.
- **WBUS:**
  - `stb_o`=1.
  - On `ack_i` or `err_i`: `stb_o` drops.
  - Remaining beats > 0 → go to WDATA and advance `addr_o`.
  - Otherwise drop `cyc_o` and go to IDLE.
- **RBUS:**
  - `stb_o`=1, `sel_o`=all ones.
  - On `ack_i`: `read_data`←`dat_i`.
  - On `err_i` or timeout: `read_data`←0.
  - Then set `read_valid`=1, drop `stb_o`, go to RHOLD.
- **RHOLD:**
  - `read_valid` holds until `read_ready`.
  - Then clear `read_valid` and either go to RBUS (more beats, advance `addr_o`) or go to IDLE and drop `cyc_o`.
- **Address arithmetic:**
  - `addr_o` += SW per beat.
  - Modulo 2^ADDR_WIDTH: 0xFFFFFFFC + 4 wraps to 0.
  - Low address bits pass through unaltered.
- **cti_o / bte_o:**
  - BURST_MODE=1 and beat count > 1: `cti_o`=3'b010 on all beats except the last, which uses 3'b111.
  - Otherwise `cti_o`=3'b000.
  - `bte_o`=2'b00 always.
- **Errors:**
  - `err_i` terminates a beat exactly like `ack_i`. If `ack_i` and `err_i` are high in the same cycle, the beat counts as an error.
  - Each errored beat increments `err_count_o` (saturating).
  - Transfers never abort early; the MAM stream stays beat-aligned.
- **Timeout:**
  - A counter runs while `stb_o`=1.
  - At TIMEOUT_CYCLES cycles without termination, the beat is treated as `err_i`.
  - The counter clears on each new strobe.
- **Reset mid-transfer:** all outputs return to their reset values immediately (asynchronously), with no bus completion.

## Timing
- Request accept → `cyc_o`/`stb_o` (read) one cycle later.
- Write: data accepted in cycle N → `stb_o` in N+1. With ack in N+1, `write_ready` is high in N+2. Minimum 2 cycles per write beat.
- Read: ack in cycle M → `read_valid` in M+1. With `read_ready` high in M+1, the next `stb_o` comes in M+2. Minimum 2 cycles per read beat.
- `cyc_o` stays continuously high across all beats of one request. `stb_o` may drop between beats.
- `req_ready` returns in the cycle after `cyc_o` falls. There is at least one IDLE cycle between requests.
- `write_ready` and `read_valid` are never high outside WDATA and RHOLD respectively.

## Test plan
- **Single write:** DATA_WIDTH=32, write to 0x100, data 0xDEADBEEF, strb 4'b0011.
  - Expect: one strobe, `sel_o`=0011, `cti_o`=000, `cyc_o` low after ack.
  - Expect: `req_ready` back 1 cycle later.
- **4-beat read burst from 0x200, zero-wait slave:**
  - Expect: addresses 0x200, 0x204, 0x208, 0x20C; `cti_o` 010, 010, 010, 111.
  - Expect: `cyc_o` continuously high; 4 `read_valid` pulses with the slave data.
- **Back-pressure:** hold `read_ready` low 5 cycles on beat 2.
  - Expect: `read_valid` and `read_data` stable, no new strobe until the handshake.
- **Error and timeout:**
  - 3-beat write with `err_i` on beat 2: expect all 3 beats issued and `err_count_o`=1.
  - Read with TIMEOUT_CYCLES=16 and a silent slave: expect `read_data`=0 after 16 strobe cycles and `err_count_o`=2.
- **Wrap and width:** DATA_WIDTH=64, 2-beat write at 0xFFFFFFF8.
  - Expect: second beat address 0x00000000, `sel_o` 8-bit.
  - Then `req_beats`=0 with `req_burst`=1: expect exactly 1 beat.
- **Reset mid-transfer:** assert `rst_i` during beat 3 of an 8-beat read.
  - Expect: all outputs 0 asynchronously.
  - Expect: a fresh request after reset completes normally.
